// File: rtl/hazard_scoreboard.sv
// Load-use hazard scoreboard: tracks in-flight register writers (EX/MEM/WB)
// and stalls decode when a source is produced by a load still in EX.
module hazard_scoreboard (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  Raddr1_d,
    input  logic [4:0]  Raddr2_d,
    input  logic        Uses1_d,
    input  logic        Uses2_d,
    input  logic [4:0]  Waddr_d,
    input  logic        RegWrite_d,
    input  logic        MemRead_d,
    input  logic        valid_d,
    input  logic        mem_wait,
    input  logic        flush_e,
    output logic        stall_d,
    output logic [31:0] busy_mask,
    output logic [15:0] stall_cnt
);

    localparam int unsigned NREG = 32;
    localparam int unsigned CW   = 16;

    localparam logic [1:0] AGE_EX  = 2'd0;
    localparam logic [1:0] AGE_MEM = 2'd1;
    localparam logic [1:0] AGE_WB  = 2'd2;

    logic [NREG-1:0]      busy_q, busy_d;
    logic [NREG-1:0]      load_q, load_d;
    logic [NREG-1:0][1:0] age_q, age_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 src1_hit, src2_hit, issue;

    // Hazard detect: only a load still in EX cannot be forwarded in time
    always_comb begin
        src1_hit = Uses1_d && (Raddr1_d != 5'd0) && busy_q[Raddr1_d]
                   && load_q[Raddr1_d] && (age_q[Raddr1_d] == AGE_EX);
        src2_hit = Uses2_d && (Raddr2_d != 5'd0) && busy_q[Raddr2_d]
                   && load_q[Raddr2_d] && (age_q[Raddr2_d] == AGE_EX);
        stall_d  = valid_d && (src1_hit || src2_hit);
        issue    = valid_d && !stall_d && !mem_wait && !flush_e
                   && RegWrite_d && (Waddr_d != 5'd0);
    end

    // Entry aging and issue; issue overrides the aging of the same entry
    always_comb begin
        busy_d = busy_q;
        load_d = load_q;
        age_d  = age_q;
        if (!mem_wait) begin
            for (int unsigned i = 1; i < NREG; i++) begin
                if (busy_q[i]) begin
                    case (age_q[i])
                        AGE_EX:  age_d[i] = AGE_MEM;
                        AGE_MEM: age_d[i] = AGE_WB;
                        default: begin
                            busy_d[i] = 1'b0;
                            load_d[i] = 1'b0;
                            age_d[i]  = AGE_EX;
                        end
                    endcase
                end
            end
            if (issue) begin
                busy_d[Waddr_d] = 1'b1;
                load_d[Waddr_d] = MemRead_d;
                age_d[Waddr_d]  = AGE_EX;
            end
        end
        busy_d[0] = 1'b0;
        load_d[0] = 1'b0;
        age_d[0]  = AGE_EX;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall_d && (cnt_q != {CW{1'b1}})) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            load_q <= '0;
            age_q  <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            load_q <= load_d;
            age_q  <= age_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_mask = busy_q;
    assign stall_cnt = cnt_q;

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The module SHALL use one clock; reset is asynchronous and active-low.
REQ-002 The ports SHALL be as follows; clk is the input clock.
REQ-003 rst_n  input  1  async active-low reset.
REQ-004 Raddr1_d, Raddr2_d  input  5 each  decode-stage source register addresses.
REQ-005 Uses1_d, Uses2_d  input  1 each  decode instruction actually reads the matching source.
REQ-006 Waddr_d  input  5  decode-stage destination register.
REQ-007 RegWrite_d  input  1  decode instruction writes Waddr_d.
REQ-008 MemRead_d  input  1  decode instruction is a load.
REQ-009 valid_d  input  1  decode holds a real instruction.
REQ-010 mem_wait  input  1  data memory not ready; the whole pipeline freezes this cycle.
REQ-011 flush_e  input  1  the instruction entering EX this edge is killed (branch redirect).
REQ-012 stall_d  output  1  hold PC and IF/ID, and insert a bubble into EX.
REQ-013 busy_mask  output  32  bit r is set while any tracked writer of xr is in flight.
REQ-014 stall_cnt  output  16  saturating count of cycles with stall_d=1.

Function
REQ-015 Each register r (1..31) SHALL hold one entry: busy, load, age[1:0].
- age 0 = writer in EX; age 1 = writer in MEM; age 2 = writer in WB.
REQ-016 Entry 0 SHALL never become busy; writes to x0 are ignored.
REQ-017 stall_d SHALL be combinational and SHALL be 1 when all of the following hold:
- valid_d=1;
- for some used source s, with s != 0: entry[s].busy=1, entry[s].load=1, and entry[s].age=0.
REQ-018 stall_d SHALL be 0 for non-load producers at any age, because those are forwardable.
REQ-019 stall_d SHALL be 0 for load producers at age 1 or 2.
REQ-020 Issue SHALL occur at a clock edge with valid_d=1, stall_d=0, mem_wait=0, flush_e=0, RegWrite_d=1 and Waddr_d != 0.
REQ-021 On issue, entry[Waddr_d] SHALL be overwritten with busy=1, load=MemRead_d, age=0.
- An older writer of the same register SHALL be replaced; the youngest writer wins.
REQ-022 On each edge with mem_wait=0, every busy entry not being issued this edge SHALL advance:
- age 0 to 1;
- age 1 to 2;
- age 2 to cleared (busy=0, load=0, age=0).
REQ-023 On edges with mem_wait=1, no entry SHALL change and no issue SHALL occur; stall_d keeps its combinational value.
REQ-024 On an edge with flush_e=1 and mem_wait=0, no issue SHALL occur; existing entries SHALL still advance.
- Age-0 entries SHALL advance normally: the killed instruction is the one leaving decode, not the one in EX.
REQ-025 Simultaneous issue to register r while r's old entry advances SHALL resolve as issue wins (REQ-021).
REQ-026 Latency: a load issued at edge N SHALL stall a dependent decode instruction during cycle N+1 only.
- At edge N+1 the load moves to age 1, so stall_d=0 in cycle N+2, assuming mem_wait=0.
REQ-027 Each mem_wait cycle SHALL extend the stall window by exactly one cycle.
REQ-028 busy_mask SHALL be registered state, equal to the busy bits, with bit 0 always 0.
REQ-029 stall_cnt SHALL increment by 1 on every edge where stall_d=1.
- It SHALL hold at 16'hFFFF once reached, with no wrap.

Reset
REQ-030 While rst_n=0, all entries SHALL be cleared asynchronously: busy_mask=0, stall_cnt=0, and stall_d=0.
REQ-031 A reset asserted mid-stall SHALL drop stall_d in the same cycle.
- After reset release, the first valid decode SHALL issue without stalling.

Verification
REQ-032 Load-use: issue lw x5; next cycle add x6,x5,x1 with valid_d=1 -> stall_d=1 for exactly 1 cycle, stall_cnt=1, busy_mask[5]=1 for 3 cycles.
REQ-033 ALU-use: issue add x5; next cycle a reader of x5 -> stall_d=0; busy_mask[5] clears after 3 edges.
REQ-034 Memory wait: lw x7, then a reader of x7 with mem_wait=1 for 2 cycles -> stall_d=1 for 3 cycles, and the entry is frozen at age 0 throughout.
REQ-035 x0 and unused source: lw x0 followed by a reader of x0 -> stall_d=0 and busy_mask=0; lw x3 followed by an instruction with Raddr1_d=3 and Uses1_d=0 -> stall_d=0.
REQ-036 Flush and overwrite: lw x4, then add x4 -> entry[4].load=0 and a following reader of x4 is not stalled; issue with flush_e=1 -> no entry set.
REQ-037 Reset mid-stall: assert rst_n=0 while stall_d=1 -> stall_d=0 immediately, busy_mask=0, stall_cnt=0.
